inst_rom_ctrl: RTL and testbench

- Responder end of the CPU instruction-fetch interface.
- The CPU drives rom_ce/rom_addr; this block returns rom_data within the same cycle.
- It owns a word-addressed instruction RAM, filled through a byte-serial loader port with a valid/ready handshake.
- It holds the CPU in reset (cpu_hold_o) until a program load completes, so the CPU never fetches a partial image.

---
 rtl/inst_rom_ctrl.sv | 167 ++++++++++++++++
 tb/tb_inst_rom_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_ctrl.sv
// Instruction RAM responder for the CPU fetch port. A byte-serial loader fills
// the RAM. The CPU is held in reset until a complete image is resident.
module inst_rom_ctrl #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rom_ce_i,
  input  logic [31:0]           rom_addr_i,
  output logic [31:0]           rom_data_o,
  input  logic                  ld_start_i,
  input  logic [ADDR_WIDTH:0]   ld_len_i,
  input  logic [7:0]            ld_byte_i,
  input  logic                  ld_valid_i,
  output logic                  ld_ready_o,
  output logic                  ld_done_o,
  output logic                  ld_err_o,
  output logic                  cpu_hold_o
);

  localparam int                DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH:0]     len_q, len_d;
  logic [ADDR_WIDTH:0]     word_ptr_q, word_ptr_d;
  logic [1:0]              byte_cnt_q, byte_cnt_d;
  logic [23:0]             shift_q, shift_d;
  logic                    ld_ready_q, ld_ready_d;
  logic                    ld_done_q, ld_done_d;
  logic                    ld_err_q, ld_err_d;
  logic                    cpu_hold_q, cpu_hold_d;

  logic                    accept_s;
  logic                    mem_we_s;
  logic [ADDR_WIDTH-1:0]   mem_waddr_s;
  logic [31:0]             mem_wdata_s;
  logic                    addr_in_range_s;
  logic                    unused_addr_s;

  logic [31:0]             mem [0:DEPTH-1];

  // A load length is usable when it is non-zero and fits the RAM.
  function automatic logic len_ok(input logic [ADDR_WIDTH:0] len);
    return (len != '0) && (len <= MAX_LEN);
  endfunction

  // ready_q mirrors the LOAD state, so it doubles as the "in LOAD" qualifier.
  assign accept_s        = ld_valid_i && ld_ready_q;
  assign addr_in_range_s = (rom_addr_i[31:ADDR_WIDTH+2] == '0);
  // Byte lane bits are don't-care on a word-addressed fetch.
  assign unused_addr_s   = ^rom_addr_i[1:0];

  // Next-state, load assembly and registered-output decode.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_ptr_d  = word_ptr_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    ld_err_d    = 1'b0;
    mem_we_s    = 1'b0;
    mem_waddr_s = word_ptr_q[ADDR_WIDTH-1:0];
    mem_wdata_s = {shift_q, ld_byte_i};

    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (ld_start_i) begin
          if (len_ok(ld_len_i)) begin
            state_d    = ST_LOAD;
            len_d      = ld_len_i;
            word_ptr_d = '0;
            byte_cnt_d = 2'd0;
            shift_d    = 24'h0;
          end else begin
            ld_err_d   = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          if (byte_cnt_q == 2'd3) begin
            // Fourth byte completes a big-endian word: commit it now.
            mem_we_s   = 1'b1;
            word_ptr_d = word_ptr_q + ONE;
            byte_cnt_d = 2'd0;
            shift_d    = 24'h0;
            if ((word_ptr_q + ONE) == len_q) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_LOAD;
            end
          end else begin
            shift_d    = {shift_q[15:0], ld_byte_i};
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ld_ready_d = (state_d == ST_LOAD);
    ld_done_d  = (state_d == ST_RUN);
    cpu_hold_d = (state_d != ST_RUN);
  end

  // Control state and registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      word_ptr_q <= '0;
      byte_cnt_q <= 2'd0;
      shift_q    <= 24'h0;
      ld_ready_q <= 1'b0;
      ld_done_q  <= 1'b0;
      ld_err_q   <= 1'b0;
      cpu_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_ptr_q <= word_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      ld_ready_q <= ld_ready_d;
      ld_done_q  <= ld_done_d;
      ld_err_q   <= ld_err_d;
      cpu_hold_q <= cpu_hold_d;
    end
  end

  // Instruction RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Zero-latency fetch; returns NOP while held or out of range.
  always_comb begin
    rom_data_o = 32'h0;
    if (rom_ce_i && !cpu_hold_q && addr_in_range_s) begin
      rom_data_o = mem[rom_addr_i[ADDR_WIDTH+1:2]];
    end else begin
      rom_data_o = 32'h0;
    end
  end

  assign ld_ready_o = ld_ready_q;
  assign ld_done_o  = ld_done_q;
  assign ld_err_o   = ld_err_q;
  assign cpu_hold_o = cpu_hold_q;

endmodule

// File: tb/tb_inst_rom_ctrl.sv
// Self-checking bench for inst_rom_ctrl: a behavioural loader/fetch model is
// compared every cycle, plus literal expectations for the directed scenarios.
module tb_inst_rom_ctrl;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rom_ce_i = 1'b0;
  logic [31:0]   rom_addr_i = 32'h0;
  logic [31:0]   rom_data_o;
  logic          ld_start_i = 1'b0;
  logic [AW:0]   ld_len_i = '0;
  logic [7:0]    ld_byte_i = 8'h0;
  logic          ld_valid_i = 1'b0;
  logic          ld_ready_o;
  logic          ld_done_o;
  logic          ld_err_o;
  logic          cpu_hold_o;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int acc_cnt = 0;
  int snap;

  inst_rom_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_ce_i   (rom_ce_i),
    .rom_addr_i (rom_addr_i),
    .rom_data_o (rom_data_o),
    .ld_start_i (ld_start_i),
    .ld_len_i   (ld_len_i),
    .ld_byte_i  (ld_byte_i),
    .ld_valid_i (ld_valid_i),
    .ld_ready_o (ld_ready_o),
    .ld_done_o  (ld_done_o),
    .ld_err_o   (ld_err_o),
    .cpu_hold_o (cpu_hold_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = waiting for a load, 1 = loading, 2 = image resident
  int          m_mode  = 0;
  int          m_len   = 0;
  int          m_words = 0;
  int          m_n     = 0;
  logic [31:0] m_acc   = 32'h0;
  bit          m_err   = 1'b0;
  logic [31:0] m_mem   [0:(1<<AW)-1];
  bit          m_known [0:(1<<AW)-1];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode <= 0;
      m_err  <= 1'b0;
      m_n    <= 0;
      m_acc  <= 32'h0;
    end else begin
      m_err <= 1'b0;
      if (m_mode == 1) begin
        if (ld_valid_i) begin
          if (m_n == 3) begin
            m_mem[m_words]   <= m_acc | {24'h0, ld_byte_i};
            m_known[m_words] <= 1'b1;
            m_words          <= m_words + 1;
            m_n              <= 0;
            m_acc            <= 32'h0;
            if (m_words + 1 == m_len) m_mode <= 2;
          end else begin
            m_acc <= m_acc | (32'(ld_byte_i) << (24 - 8 * m_n));
            m_n   <= m_n + 1;
          end
        end
      end else if (ld_start_i) begin
        if (int'(ld_len_i) >= 1 && int'(ld_len_i) <= (1 << AW)) begin
          m_mode  <= 1;
          m_len   <= int'(ld_len_i);
          m_words <= 0;
          m_n     <= 0;
          m_acc   <= 32'h0;
        end else begin
          m_err <= 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", 32'(ld_ready_o), 32'(m_mode == 1));
      chk("done",  32'(ld_done_o),  32'(m_mode == 2));
      chk("hold",  32'(cpu_hold_o), 32'(m_mode != 2));
      chk("err",   32'(ld_err_o),   32'(m_err));
      if (rom_ce_i && m_mode == 2 && rom_addr_i < 32'h0000_1000) begin
        if (m_known[rom_addr_i[11:2]]) chk("rom_data", rom_data_o, m_mem[rom_addr_i[11:2]]);
      end else begin
        chk("rom_data_nop", rom_data_o, 32'h0);
      end
    end
  end

  // Handshake acceptance counter.
  always @(posedge clk) begin
    if (rst && ld_valid_i && ld_ready_o) acc_cnt <= acc_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int len);
    ld_start_i = 1'b1;
    ld_len_i   = (AW + 1)'(len);
    tick();
    ld_start_i = 1'b0;
  endtask

  task automatic fetch(input string name, input logic [31:0] addr, input logic [31:0] exp);
    rom_addr_i = addr;
    #1;
    chk(name, rom_data_o, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] img2 [8];
    logic [7:0] img1 [4];
    logic [7:0] img3 [4];
    img2 = '{8'h34, 8'h01, 8'h00, 8'h05, 8'h24, 8'h02, 8'h00, 8'h07};
    img1 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    img3 = '{8'h11, 8'h22, 8'h33, 8'h44};

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Reset then idle
    rom_ce_i = 1'b1;
    fetch("reset_rom", 32'h0, 32'h0);
    chk("reset_hold",  32'(cpu_hold_o), 32'd1);
    chk("reset_ready", 32'(ld_ready_o), 32'd0);
    chk("reset_done",  32'(ld_done_o),  32'd0);
    rst = 1'b1;
    tick();
    tick();

    // Rejected lengths from IDLE
    start(0);
    chk("err_len0", 32'(ld_err_o), 32'd1);
    chk("err_len0_ready", 32'(ld_ready_o), 32'd0);
    tick();
    chk("err_len0_pulse", 32'(ld_err_o), 32'd0);
    start(1025);
    chk("err_len1025", 32'(ld_err_o), 32'd1);
    tick();
    chk("err_len1025_pulse", 32'(ld_err_o), 32'd0);
    chk("err_hold", 32'(cpu_hold_o), 32'd1);

    // Back-to-back load of two words
    start(2);
    ld_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ld_byte_i = img2[i];
      tick();
    end
    ld_valid_i = 1'b0;
    chk("load2_done", 32'(ld_done_o),  32'd1);
    chk("load2_hold", 32'(cpu_hold_o), 32'd0);
    fetch("load2_addr0", 32'h0, 32'h3401_0005);
    fetch("load2_addr4", 32'h4, 32'h2402_0007);
    fetch("load2_addr6", 32'h6, 32'h2402_0007);

    // Reload from RUN with valid toggling every cycle
    start(1);
    chk("reload_hold", 32'(cpu_hold_o), 32'd1);
    fetch("reload_nop", 32'h0, 32'h0);
    snap = acc_cnt;
    for (int i = 0; i < 4; i++) begin
      ld_valid_i = 1'b1;
      ld_byte_i  = img1[i];
      tick();
      ld_valid_i = 1'b0;
      tick();
    end
    ld_valid_i = 1'b1;
    ld_byte_i  = 8'hAA;
    #1;
    chk("extra_byte_ready", 32'(ld_ready_o), 32'd0);
    tick();
    ld_valid_i = 1'b0;
    chk("toggle_accepts", 32'(acc_cnt - snap), 32'd4);
    fetch("toggle_addr0", 32'h0, 32'hDEAD_BEEF);
    fetch("stale_addr4",  32'h4, 32'h2402_0007);

    // RUN-state fetch gating and rejected start
    fetch("oor_addr", 32'h0000_1000, 32'h0);
    rom_ce_i = 1'b0;
    fetch("ce_low", 32'h0, 32'h0);
    rom_ce_i = 1'b1;
    start(0);
    chk("run_err", 32'(ld_err_o), 32'd1);
    chk("run_err_done", 32'(ld_done_o), 32'd1);
    tick();

    // Asynchronous reset after 6 of 8 bytes
    start(2);
    ld_valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ld_byte_i = img2[i] ^ 8'h5A;
      tick();
    end
    ld_valid_i = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_hold",  32'(cpu_hold_o), 32'd1);
    chk("midrst_ready", 32'(ld_ready_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    start(1);
    ld_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ld_byte_i = img3[i];
      tick();
    end
    ld_valid_i = 1'b0;
    fetch("restart_addr0", 32'h0, 32'h1122_3344);
    tick();
    tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
